// File: rtl/segments_scanner.sv
// segments_scanner: time-multiplexed scanner for a DIGITS-wide packed BCD
// display. A value is loaded with a valid/ready handshake into a pending
// register and only becomes the displayed (active) value when the scan wraps
// back to digit 0. A new value therefore never takes effect mid-frame.
//
// Optional feature: define SEGMENTS_LEADING_ZERO_BLANK_EN to blank leading
// zero digits (digit 0 is always shown). Without the macro no digit is blanked.
//
// digit_select polarity: CONTROL_TYPE_V = 0 -> active-low (common cathode),
// CONTROL_TYPE_V = 1 -> active-high (common anode).

`timescale 1ns/1ps

module segments_scanner #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned REFRESH_DIV    = 1000,
    parameter logic        CONTROL_TYPE_V = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_data,
    output logic [3:0]            data_bus,
    output logic [DIGITS-1:0]     digit_select,
    output logic                  frame_done
);

    localparam int unsigned DW = $clog2(REFRESH_DIV);
    localparam int unsigned IW = $clog2(DIGITS);

    localparam logic [DW-1:0] DWELL_LAST = DW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] INDEX_LAST = IW'(DIGITS - 1);

    // Level that enables a digit, and the level that leaves it dark.
    localparam logic SEL_ON  = CONTROL_TYPE_V;
    localparam logic SEL_OFF = ~CONTROL_TYPE_V;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [4*DIGITS-1:0] active_q,       active_d;
    logic [4*DIGITS-1:0] pending_q,      pending_d;
    logic                pending_full_q, pending_full_d;
    logic [DW-1:0]       dwell_q,        dwell_d;
    logic [IW-1:0]       idx_q,          idx_d;
    logic [3:0]          data_bus_q,     data_bus_d;
    logic [DIGITS-1:0]   digit_select_q, digit_select_d;
    logic                frame_done_q,   frame_done_d;

    // ------------------------------------------------------------------
    // Derived control
    // ------------------------------------------------------------------
    logic              dwell_wrap;
    logic              frame_wrap;
    logic              load_accept;
    logic [DIGITS-1:0] blank_mask;

    assign dwell_wrap  = (dwell_q == DWELL_LAST);
    assign frame_wrap  = dwell_wrap && (idx_q == INDEX_LAST);

    // Ready depends on the flag alone so an upstream valid can never loop back.
    assign load_ready  = !pending_full_q;
    assign load_accept = load_valid && !pending_full_q;

    // ------------------------------------------------------------------
    // Dwell counter and digit index: each digit is held REFRESH_DIV cycles.
    // ------------------------------------------------------------------
    always_comb begin : scan_next
        dwell_d = dwell_q + DW'(1);
        idx_d   = idx_q;
        if (dwell_wrap) begin
            dwell_d = '0;
            if (idx_q == INDEX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending/active transfer: promote at the frame wrap, then accept.
    // The promote is evaluated before the accept so a handshake on the wrap
    // edge lands in pending and is shown from the following frame only.
    // ------------------------------------------------------------------
    always_comb begin : load_next
        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        frame_done_d   = frame_wrap;

        if (frame_wrap && pending_full_q) begin
            active_d       = pending_q;
            pending_full_d = 1'b0;
        end

        if (load_accept) begin
            pending_d      = load_data;
            pending_full_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero blanking mask over the active value.
    // ------------------------------------------------------------------
`ifdef SEGMENTS_LEADING_ZERO_BLANK_EN
    // Walk from the most significant digit down; a digit is dark while every
    // digit above it (and itself) is zero. Digit 0 always stays lit.
    always_comb begin : blank_calc
        logic zero_run;
        blank_mask = '0;
        zero_run   = 1'b1;
        for (int unsigned j = 0; j < DIGITS - 1; j++) begin
            zero_run = zero_run && (active_q[4*(DIGITS-1-j) +: 4] == 4'h0);
            blank_mask[DIGITS-1-j] = zero_run;
        end
    end
`else
    // No blanking in this build: every slot drives its digit.
    always_comb begin : blank_calc
        blank_mask = '0;
    end
`endif

    // ------------------------------------------------------------------
    // Output decode for the digit the index currently points at.
    // ------------------------------------------------------------------
    always_comb begin : display_next
        logic [3:0] cur_nibble;
        logic       cur_blank;
        cur_nibble     = 4'h0;
        cur_blank      = 1'b0;
        data_bus_d     = 4'h0;
        digit_select_d = {DIGITS{SEL_OFF}};

        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_nibble = active_q[4*k +: 4];
                cur_blank  = blank_mask[k];
            end
        end

        if (!cur_blank) begin
            data_bus_d = cur_nibble;
            for (int unsigned k = 0; k < DIGITS; k++) begin
                if (idx_q == IW'(k)) begin
                    digit_select_d[k] = SEL_ON;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // All state, cleared asynchronously; outputs lag the index by one cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin : state_reg
        if (!reset_n) begin
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            dwell_q        <= '0;
            idx_q          <= '0;
            data_bus_q     <= 4'h0;
            digit_select_q <= {DIGITS{SEL_OFF}};
            frame_done_q   <= 1'b0;
        end else begin
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            dwell_q        <= dwell_d;
            idx_q          <= idx_d;
            data_bus_q     <= data_bus_d;
            digit_select_q <= digit_select_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign data_bus     = data_bus_q;
    assign digit_select = digit_select_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_segments_scanner.sv
// Testbench for segments_scanner (DIGITS=4, REFRESH_DIV=4, common cathode).
// Expected display is derived from the elapsed cycle count since reset and a
// transaction-level view of the pending/active registers.

`timescale 1ns/1ps

module tb_segments_scanner;

    localparam int unsigned D     = 4;
    localparam int unsigned RD    = 4;
    localparam int unsigned FRAME = D * RD;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_data  = 16'h0;
    logic        load_ready;
    logic [3:0]  data_bus;
    logic [3:0]  digit_select;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int unsigned n;          // rising edges since reset release
    logic [15:0] m_active;
    logic [15:0] m_pending;
    bit          m_full;
    bit          m_accepted; // handshake completed on the latest edge

    segments_scanner #(
        .DIGITS         (4),
        .REFRESH_DIV    (4),
        .CONTROL_TYPE_V (1'b0)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .data_bus     (data_bus),
        .digit_select (digit_select),
        .frame_done   (frame_done)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // What the display should show for a given value and digit position.
    function automatic void exp_display(input logic [15:0] act, input int unsigned idx,
                                        output logic [3:0] db, output logic [3:0] ds);
        logic [15:0] upper;
        bit          blank;
        upper = act >> (4 * idx);
        blank = 1'b0;
`ifdef SEGMENTS_LEADING_ZERO_BLANK_EN
        blank = (idx >= 1) && (upper == 16'h0);
`endif
        if (blank) begin
            db = 4'h0;
            ds = 4'hF;
        end else begin
            db = upper[3:0];
            ds = ~(4'b0001 << idx);
        end
    endfunction

    // One clock edge: advance the model with the inputs presented, then check.
    task automatic step();
        logic        v;
        logic [15:0] d;
        logic [15:0] act_b;
        int unsigned idx_b;
        logic [3:0]  edb;
        logic [3:0]  eds;
        bit          wrap;
        v     = load_valid;
        d     = load_data;
        act_b = m_active;
        @(posedge clk);
        #1;
        n++;
        idx_b = ((n - 1) / RD) % D;
        exp_display(act_b, idx_b, edb, eds);
        wrap       = (n % FRAME) == 0;
        m_accepted = v && !m_full;
        if (wrap && m_full) begin
            m_active = m_pending;
            m_full   = 1'b0;
        end
        if (m_accepted) begin
            m_pending = d;
            m_full    = 1'b1;
        end
        check("data_bus",     32'(data_bus),     32'(edb));
        check("digit_select", 32'(digit_select), 32'(eds));
        check("frame_done",   32'(frame_done),   32'(wrap));
        check("load_ready",   32'(load_ready),   32'(!m_full));
    endtask

    // Assert reset at the current time, hold it for some edges, release it
    // just after a rising edge.
    task automatic apply_reset(input int unsigned cycles);
        reset_n    = 1'b0;
        load_valid = 1'b0;
        #1;
        check("rst_async_digit_select", 32'(digit_select), 32'h0000_000F);
        check("rst_async_data_bus",     32'(data_bus),     32'h0);
        check("rst_async_load_ready",   32'(load_ready),   32'h1);
        check("rst_async_frame_done",   32'(frame_done),   32'h0);
        repeat (cycles) @(posedge clk);
        #1;
        check("rst_hold_digit_select",  32'(digit_select), 32'h0000_000F);
        check("rst_hold_data_bus",      32'(data_bus),     32'h0);
        check("rst_hold_load_ready",    32'(load_ready),   32'h1);
        reset_n   = 1'b1;
        n         = 0;
        m_active  = 16'h0;
        m_pending = 16'h0;
        m_full    = 1'b0;
    endtask

    initial begin
        int          fd_count;
        bit          got;
        logic [15:0] vals [4];

        // Reset, then digit 0 on the first edge
        #2;
        apply_reset(3);
        step();
        check("first_edge_digit_select", 32'(digit_select), 32'h0000_000E);
        check("first_edge_data_bus",     32'(data_bus),     32'h0);

        // Load 1234 and scan it
        load_valid = 1'b1;
        load_data  = 16'h1234;
        step();
        load_valid = 1'b0;
        check("load_ready_after_load", 32'(load_ready), 32'h0);
        repeat (2 * FRAME) step();

        // Back-pressure: 5678 offered while 1234 still pending
        load_valid = 1'b1;
        load_data  = 16'h1234;
        step();
        load_data  = 16'h5678;
        got = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step();
            if (m_accepted) begin
                got = 1'b1;
                break;
            end
        end
        load_valid = 1'b0;
        check("backpressure_accept_in_time", 32'(got), 32'h1);
        repeat (3 * FRAME) step();

        // Handshake coinciding with the frame wrap, pending empty
        for (int i = 0; i < FRAME && ((n + 1) % FRAME) != 0; i++) step();
        load_valid = 1'b1;
        load_data  = 16'h9ABC;
        step();
        load_valid = 1'b0;
        check("coincident_load_ready", 32'(load_ready), 32'h0);
        fd_count = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            fd_count += int'(frame_done);
        end
        check("coincident_frame_done_count", 32'(fd_count), 32'h1);
        repeat (2 * FRAME) step();

        // Leading-zero patterns (blanked only when the macro is defined)
        vals[0] = 16'h0070;
        vals[1] = 16'h0000;
        vals[2] = 16'h0A05;
        vals[3] = 16'hF00B;
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 4 * FRAME && m_full; i++) step();
            load_valid = 1'b1;
            load_data  = vals[v];
            step();
            load_valid = 1'b0;
            repeat (2 * FRAME) step();
        end

        // Reset mid-frame with a value pending
        for (int i = 0; i < FRAME && (n % FRAME) != 1; i++) step();
        load_valid = 1'b1;
        load_data  = 16'h4321;
        step();
        load_valid = 1'b0;
        repeat (5) step();
        check("pending_full_before_reset", 32'(load_ready), 32'h0);
        apply_reset(2);
        repeat (2 * FRAME) step();

        // Randomized offers; an offer is held until it is accepted
        for (int i = 0; i < 500; i++) begin
            if (!load_valid || m_accepted) begin
                load_valid = ($urandom_range(0, 3) == 0);
                load_data  = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
            end
            step();
        end
        load_valid = 1'b0;
        repeat (2 * FRAME) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/segments_scanner.md
SEGMENTS_SCANNER -- requirements
Module: segments_scanner

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 1000, clock cycles each digit is shown (>=2).
REQ-003 SHALL have parameter CONTROL_TYPE_V, default 1'b0; 0 = common cathode (digit_select active-low), 1 = common anode (digit_select active-high).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port load_valid  input  1  load_data is offered.
REQ-007 SHALL have port load_ready  output  1  block can accept a new value.
REQ-008 SHALL have port load_data  input  4*DIGITS  packed BCD; digit k = bits [4k+3:4k], digit 0 least significant.
REQ-009 SHALL have port data_bus  output  4  nibble of the digit currently scanned; feeds segments_driver data_bus.
REQ-010 SHALL have port digit_select  output  DIGITS  one-hot digit enable, polarity per CONTROL_TYPE_V.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse when the scan wraps to digit 0.

Function
REQ-012 SHALL hold an active register (displayed value) and a pending register with a pending_full flag.
REQ-013 SHALL complete a transfer when load_valid and load_ready are both high at a rising edge; load_data goes to pending, pending_full sets.
REQ-014 SHALL drive load_ready = !pending_full, combinationally from the flag only, never from load_valid.
REQ-015 SHALL run a dwell counter 0..REFRESH_DIV-1; at REFRESH_DIV-1 it wraps to 0 and the digit index advances, wrapping DIGITS-1 -> 0.
REQ-016 SHALL, on the edge where the index wraps DIGITS-1 -> 0, copy pending to active if pending_full, clear pending_full, and assert frame_done for exactly that following cycle.
REQ-017 SHALL, if a handshake and the frame wrap coincide with pending empty, accept the new value into pending; it is displayed from the next frame, not the current one.
REQ-018 SHALL not accept while pending_full; load_data is ignored and the offer remains outstanding.
REQ-019 SHALL register data_bus and digit_select; both reflect the new index in the cycle after the index changes, with latency 1 cycle from an index change.
REQ-020 SHALL assert exactly one digit_select bit per dwell slot, except for blanked slots (REQ-026).
REQ-021 SHALL pass nibble values 10..15 to data_bus unmodified; overflow handling belongs to segments_driver.
REQ-022 SHALL keep a new active value from taking effect mid-frame; every frame shows a single consistent value.

Reset
REQ-023 SHALL, while reset_n = 0, asynchronously force: active = 0, pending = 0, pending_full = 0, index = 0, dwell counter = 0, data_bus = 4'b0000, frame_done = 0, digit_select all inactive, load_ready = 1.
REQ-024 SHALL assert digit 0 on data_bus/digit_select on the first rising edge after reset_n deasserts.
REQ-025 SHALL, on reset mid-frame or with pending_full set, discard the pending value, with no frame_done pulse.

Configuration
REQ-026 SHALL, with macro SEGMENTS_LEADING_ZERO_BLANK_EN defined, blank digit k (k >= 1) when it and all more significant active digits are 0; in a blanked slot digit_select is all inactive, data_bus = 4'b0000, and slot timing is unchanged.
REQ-027 SHALL, without SEGMENTS_LEADING_ZERO_BLANK_EN, never blank; digit 0 is never blanked in either build.

Verification (DIGITS=4, REFRESH_DIV=4, CONTROL_TYPE_V=0)
REQ-028 SHALL cover reset: hold reset_n=0 -> digit_select=4'b1111, data_bus=0, load_ready=1; release -> next edge digit_select=4'b1110, data_bus=0.
REQ-029 SHALL cover load and scan: load 16'h1234 -> load_ready=0 until the wrap; next frame shows data_bus 4,3,2,1 with digit_select 1110,1101,1011,0111, 4 cycles each, frame_done every 16 cycles.
REQ-030 SHALL cover back-pressure: offer 16'h5678 while pending holds 16'h1234 -> not accepted until after the wrap; 1234 shown one frame, then 5678.
REQ-031 SHALL cover coincident wrap: handshake on the wrap edge with pending empty -> value appears one full frame later; frame_done pulses once.
REQ-032 SHALL cover blanking (macro defined): load 16'h0070 -> digits 3,2 blanked (digit_select 1111), digit 1 = 7, digit 0 = 0; without the macro, all four digits are driven.
REQ-033 SHALL cover mid-frame reset: assert reset_n=0 with pending_full=1 -> after release, display 0, load_ready=1, no stale value shown.
